// File: rtl/alu_issue_if.sv
// alu_issue_if -- bundles the request, ALU and result handshake signals of
// alu_issue into one bus.
//   slave  : view used by alu_issue (takes requests and ALU response, drives
//            ALU operands and the captured result)
//   master : the opposite view, for the decode stage / ALU / consumer side
// Signal names match the original flat port list of alu_issue.
interface alu_issue_if #(
  parameter int CNT_W = 16
);
  // request from decode
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       aluop_i;
  logic [5:0]       funct_i;
  logic [31:0]      src1_i;
  logic [31:0]      src2_i;
  // ALU drive and response
  logic [31:0]      alu_src1_o;
  logic [31:0]      alu_src2_o;
  logic [3:0]       alu_ctrl_o;
  logic [31:0]      alu_result_i;
  logic             alu_zero_i;
  // result hand-off
  logic             valid_o;
  logic             ready_i;
  logic [31:0]      result_o;
  logic             zero_o;
  logic             illegal_o;
  logic [CNT_W-1:0] op_count_o;

  modport slave (
    input  valid_i, aluop_i, funct_i, src1_i, src2_i,
    input  alu_result_i, alu_zero_i, ready_i,
    output ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
    output valid_o, result_o, zero_o, illegal_o, op_count_o
  );

  modport master (
    output valid_i, aluop_i, funct_i, src1_i, src2_i,
    output alu_result_i, alu_zero_i, ready_i,
    input  ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
    input  valid_o, result_o, zero_o, illegal_o, op_count_o
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue -- single-slot issue stage in front of a combinational ALU.
// Accepts one request, decodes ALUOp/funct into an ALU control code, drives
// the ALU for one cycle, captures its response and holds it until the
// consumer takes it. Counts completed hand-offs.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : alu_issue_if.slave (request, ALU drive/response, result, count)
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  alu_issue_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  logic [1:0]       state_q;
  logic [31:0]      src1_q;
  logic [31:0]      src2_q;
  logic [3:0]       ctrl_q;
  logic             ill_q;
  logic [31:0]      result_q;
  logic             zero_q;
  logic             ill_res_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]       dec_ctrl;
  logic             dec_ill;
  logic             ready;
  logic             handoff;
  logic             accept;

  // ALUOp / funct decode; anything unlisted maps to the illegal code
  always_comb begin
    dec_ctrl = CTRL_ILLEGAL;
    dec_ill  = 1'b1;
    case (bus.aluop_i)
      3'b000: begin dec_ctrl = 4'b0010; dec_ill = 1'b0; end
      3'b001: begin dec_ctrl = 4'b0110; dec_ill = 1'b0; end
      3'b011: begin dec_ctrl = 4'b0111; dec_ill = 1'b0; end
      3'b100: begin dec_ctrl = 4'b0001; dec_ill = 1'b0; end
      3'b010: begin
        case (bus.funct_i)
          6'b100000: begin dec_ctrl = 4'b0010; dec_ill = 1'b0; end
          6'b100010: begin dec_ctrl = 4'b0110; dec_ill = 1'b0; end
          6'b100100: begin dec_ctrl = 4'b0000; dec_ill = 1'b0; end
          6'b100101: begin dec_ctrl = 4'b0001; dec_ill = 1'b0; end
          6'b101010: begin dec_ctrl = 4'b0111; dec_ill = 1'b0; end
          6'b100111: begin dec_ctrl = 4'b1100; dec_ill = 1'b0; end
          default:   begin dec_ctrl = CTRL_ILLEGAL; dec_ill = 1'b1; end
        endcase
      end
      default: begin dec_ctrl = CTRL_ILLEGAL; dec_ill = 1'b1; end
    endcase
  end

  // In DONE the slot frees up in the same cycle the consumer takes the result,
  // so a new request can be accepted alongside the hand-off.
  assign handoff = (state_q == DONE) && bus.ready_i;
  assign ready   = (state_q == IDLE) || handoff;
  assign accept  = bus.valid_i && ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      src1_q    <= '0;
      src2_q    <= '0;
      ctrl_q    <= CTRL_ILLEGAL;
      ill_q     <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ill_res_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (handoff) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (accept) begin
        src1_q <= bus.src1_i;
        src2_q <= bus.src2_i;
        ctrl_q <= dec_ctrl;
        ill_q  <= dec_ill;
      end

      case (state_q)
        IDLE: begin
          if (accept) state_q <= EXEC;
        end
        EXEC: begin
          result_q  <= bus.alu_result_i;
          zero_q    <= bus.alu_zero_i;
          ill_res_q <= ill_q;
          state_q   <= DONE;
        end
        DONE: begin
          if (handoff) state_q <= bus.valid_i ? EXEC : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready_o    = ready;
  assign bus.alu_src1_o = (state_q == EXEC) ? src1_q : '0;
  assign bus.alu_src2_o = (state_q == EXEC) ? src2_q : '0;
  assign bus.alu_ctrl_o = (state_q == EXEC) ? ctrl_q : CTRL_ILLEGAL;
  assign bus.valid_o    = (state_q == DONE);
  assign bus.result_o   = result_q;
  assign bus.zero_o     = zero_q;
  assign bus.illegal_o  = (state_q == DONE) && ill_res_q;
  assign bus.op_count_o = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue -- directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a transaction-level
// model (one slot: busy / result-ready, expected result from ALUOp rules).
module tb_alu_issue;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if #(.CNT_W(CW)) bus ();

  alu_issue #(.CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ALU environment: combinational response to the control code
  logic [31:0] alu_r;
  always_comb begin
    case (bus.alu_ctrl_o)
      4'b0010: alu_r = bus.alu_src1_o + bus.alu_src2_o;
      4'b0110: alu_r = bus.alu_src1_o - bus.alu_src2_o;
      4'b0000: alu_r = bus.alu_src1_o & bus.alu_src2_o;
      4'b0001: alu_r = bus.alu_src1_o | bus.alu_src2_o;
      4'b0111: alu_r = ($signed(bus.alu_src1_o) < $signed(bus.alu_src2_o)) ? 32'd1 : 32'd0;
      4'b1100: alu_r = ~(bus.alu_src1_o | bus.alu_src2_o);
      default: alu_r = 32'd0;
    endcase
    bus.alu_result_i = alu_r;
    bus.alu_zero_i   = (alu_r == 32'd0);
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // expected outcome of one operation, straight from the opcode rules
  typedef struct packed {
    logic [3:0]  ctrl;
    logic        ill;
    logic [31:0] res;
  } gold_t;

  function automatic gold_t golden(input logic [2:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b);
    gold_t g;
    logic [31:0] slt;
    slt = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    g.ctrl = 4'hF; g.ill = 1'b1; g.res = 32'd0;
    case (op)
      3'd0: begin g.ctrl = 4'b0010; g.ill = 1'b0; g.res = a + b; end
      3'd1: begin g.ctrl = 4'b0110; g.ill = 1'b0; g.res = a - b; end
      3'd3: begin g.ctrl = 4'b0111; g.ill = 1'b0; g.res = slt;   end
      3'd4: begin g.ctrl = 4'b0001; g.ill = 1'b0; g.res = a | b; end
      3'd2: begin
        case (fn)
          6'h20: begin g.ctrl = 4'b0010; g.ill = 1'b0; g.res = a + b;    end
          6'h22: begin g.ctrl = 4'b0110; g.ill = 1'b0; g.res = a - b;    end
          6'h24: begin g.ctrl = 4'b0000; g.ill = 1'b0; g.res = a & b;    end
          6'h25: begin g.ctrl = 4'b0001; g.ill = 1'b0; g.res = a | b;    end
          6'h2A: begin g.ctrl = 4'b0111; g.ill = 1'b0; g.res = slt;      end
          6'h27: begin g.ctrl = 4'b1100; g.ill = 1'b0; g.res = ~(a | b); end
          default: ;
        endcase
      end
      default: ;
    endcase
    return g;
  endfunction

  // transaction-level model: one slot, busy after accept, result ready one
  // edge later, freed by hand-off
  logic        m_busy, m_done;
  gold_t       m_op;
  logic [31:0] m_a, m_b;
  int unsigned m_cnt;
  gold_t       m_new;
  logic        exp_valid, exp_ready, m_hand, m_acc;

  always_comb begin
    m_new     = golden(bus.aluop_i, bus.funct_i, bus.src1_i, bus.src2_i);
    exp_valid = m_busy && m_done;
    m_hand    = exp_valid && bus.ready_i;
    exp_ready = !m_busy || m_hand;
    m_acc     = bus.valid_i && exp_ready;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_op   <= '0;
      m_a    <= '0;
      m_b    <= '0;
      m_cnt  <= 0;
    end else begin
      if (m_hand) m_cnt <= (m_cnt + 1) % (1 << CW);
      if (m_acc) begin
        m_busy <= 1'b1;
        m_done <= 1'b0;
        m_op   <= m_new;
        m_a    <= bus.src1_i;
        m_b    <= bus.src2_i;
      end else if (m_hand) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
      end else if (m_busy) begin
        m_done <= 1'b1;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    check("ready_o", 32'(bus.ready_o), 32'(exp_ready));
    check("valid_o", 32'(bus.valid_o), 32'(exp_valid));
    check("op_count_o", 32'(bus.op_count_o), m_cnt);
    if (exp_valid) begin
      check("result_o", bus.result_o, m_op.res);
      check("zero_o", 32'(bus.zero_o), 32'(m_op.res == 32'd0));
      check("illegal_o", 32'(bus.illegal_o), 32'(m_op.ill));
    end else begin
      check("illegal_o_quiet", 32'(bus.illegal_o), 32'd0);
    end
    if (m_busy && !m_done) begin
      check("alu_ctrl_o", 32'(bus.alu_ctrl_o), 32'(m_op.ctrl));
      check("alu_src1_o", bus.alu_src1_o, m_a);
      check("alu_src2_o", bus.alu_src2_o, m_b);
    end else begin
      check("alu_ctrl_o_idle", 32'(bus.alu_ctrl_o), 32'hF);
      check("alu_src1_o_idle", bus.alu_src1_o, 32'd0);
      check("alu_src2_o_idle", bus.alu_src2_o, 32'd0);
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid_i = v;
    bus.aluop_i = op;
    bus.funct_i = fn;
    bus.src1_i  = a;
    bus.src2_i  = b;
  endtask

  logic [5:0] legal_fn [6];

  initial begin
    legal_fn[0] = 6'h20; legal_fn[1] = 6'h22; legal_fn[2] = 6'h24;
    legal_fn[3] = 6'h25; legal_fn[4] = 6'h2A; legal_fn[5] = 6'h27;
    drive(1'b0, 3'd0, 6'd0, 32'd0, 32'd0);
    bus.ready_i = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst valid_o", 32'(bus.valid_o), 32'd0);
    check("rst result_o", bus.result_o, 32'd0);
    check("rst zero_o", 32'(bus.zero_o), 32'd0);
    check("rst illegal_o", 32'(bus.illegal_o), 32'd0);
    check("rst op_count_o", 32'(bus.op_count_o), 32'd0);
    check("rst alu_ctrl_o", 32'(bus.alu_ctrl_o), 32'hF);
    check("rst alu_src1_o", bus.alu_src1_o, 32'd0);
    edge1();
    rst = 1'b0;

    // sub 7-7
    drive(1'b1, 3'b010, 6'b100010, 32'd7, 32'd7);
    edge1();
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("sub alu_ctrl_o", 32'(bus.alu_ctrl_o), 32'h6);
    edge1();
    @(negedge clk);
    check("sub valid_o", 32'(bus.valid_o), 32'd1);
    check("sub result_o", bus.result_o, 32'd0);
    check("sub zero_o", 32'(bus.zero_o), 32'd1);
    edge1();
    @(negedge clk);
    check("sub count", 32'(bus.op_count_o), 32'd1);

    // back-to-back add 3+4, slt 5<9
    edge1();
    drive(1'b1, 3'b000, 6'd0, 32'd3, 32'd4);
    edge1();
    drive(1'b1, 3'b011, 6'd0, 32'd5, 32'd9);
    @(negedge clk);
    check("b2b exec valid_o", 32'(bus.valid_o), 32'd0);
    edge1();
    @(negedge clk);
    check("b2b add valid_o", 32'(bus.valid_o), 32'd1);
    check("b2b add result_o", bus.result_o, 32'd7);
    edge1();
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("b2b gap valid_o", 32'(bus.valid_o), 32'd0);
    edge1();
    @(negedge clk);
    check("b2b slt valid_o", 32'(bus.valid_o), 32'd1);
    check("b2b slt result_o", bus.result_o, 32'd1);
    edge1();
    @(negedge clk);
    check("b2b count", 32'(bus.op_count_o), 32'd3);

    // backpressure: or 0xF0|0x0F held for 5 cycles
    edge1();
    bus.ready_i = 1'b0;
    drive(1'b1, 3'b100, 6'd0, 32'hF0, 32'h0F);
    edge1();
    bus.valid_i = 1'b0;
    edge1();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp valid_o", 32'(bus.valid_o), 32'd1);
      check("bp result_o", bus.result_o, 32'hFF);
      check("bp ready_o", 32'(bus.ready_o), 32'd0);
      check("bp count", 32'(bus.op_count_o), 32'd3);
      edge1();
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    check("bp release ready_o", 32'(bus.ready_o), 32'd1);
    edge1();
    @(negedge clk);
    check("bp count after", 32'(bus.op_count_o), 32'd4);
    check("bp valid_o after", 32'(bus.valid_o), 32'd0);

    // illegal funct
    edge1();
    drive(1'b1, 3'b010, 6'b000000, 32'd123, 32'd456);
    edge1();
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("ill alu_ctrl_o", 32'(bus.alu_ctrl_o), 32'hF);
    edge1();
    @(negedge clk);
    check("ill valid_o", 32'(bus.valid_o), 32'd1);
    check("ill illegal_o", 32'(bus.illegal_o), 32'd1);
    check("ill result_o", bus.result_o, 32'd0);
    edge1();
    @(negedge clk);
    check("ill illegal_o after", 32'(bus.illegal_o), 32'd0);
    check("ill count", 32'(bus.op_count_o), 32'd5);

    // asynchronous reset in the middle of EXEC
    edge1();
    drive(1'b1, 3'b000, 6'd0, 32'd1, 32'd1);
    edge1();
    bus.valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async rst valid_o", 32'(bus.valid_o), 32'd0);
    check("async rst ready_o", 32'(bus.ready_o), 32'd1);
    check("async rst alu_ctrl_o", 32'(bus.alu_ctrl_o), 32'hF);
    check("async rst count", 32'(bus.op_count_o), 32'd0);
    edge1();
    edge1();
    rst = 1'b0;
    edge1();
    @(negedge clk);
    check("post rst valid_o", 32'(bus.valid_o), 32'd0);
    check("post rst count", 32'(bus.op_count_o), 32'd0);

    // 17 hand-offs wrap the 4-bit counter to 1
    edge1();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 3'b000, 6'd0, $urandom, $urandom);
      edge1();
      bus.valid_i = 1'b0;
      edge1();
      edge1();
    end
    @(negedge clk);
    check("wrap count", 32'(bus.op_count_o), 32'd1);

    // randomized traffic
    edge1();
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      rst = ($urandom_range(0, 199) == 0);
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 15)) - 32'd8;
      drive($urandom_range(0, 99) < 60,
            ($urandom_range(0, 9) < 4) ? 3'b010 : 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 8) ? legal_fn[$urandom_range(0, 5)] : 6'($urandom),
            a,
            ($urandom_range(0, 4) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8));
      bus.ready_i = ($urandom_range(0, 99) < 70);
      edge1();
    end
    rst = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (4) edge1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 valid_i  input  1  request valid from the decode stage.
REQ-005 ready_o  output  1  block can accept a request this cycle.
REQ-006 aluop_i  input  3  ALUOp class from the main control.
REQ-007 funct_i  input  6  R-type funct field.
REQ-008 src1_i, src2_i  input  32 each  request operands.
REQ-009 alu_src1_o, alu_src2_o  output  32 each  operands driven to the ALU.
REQ-010 alu_ctrl_o  output  4  ALU operation select driven to the ALU.
REQ-011 alu_result_i  input  32; alu_zero_i  input  1  combinational ALU response.
REQ-012 valid_o  output  1  result valid; ready_i  input  1  consumer accepts result.
REQ-013 result_o  output  32; zero_o  output  1; illegal_o  output  1  captured response and decode-error flag.
REQ-014 op_count_o  output  CNT_W  number of results handed off.

Function
REQ-015 FSM states IDLE, EXEC, DONE; the block SHALL hold at most one operation in flight.
REQ-016 ready_o SHALL be 1 in IDLE, equal ready_i in DONE, and 0 in EXEC.
REQ-017 Accept = valid_i & ready_o; on accept, operands and decoded ctrl SHALL be registered and the state SHALL move to EXEC.
REQ-018 In EXEC, alu_src1_o/alu_src2_o/alu_ctrl_o SHALL present the registered values; at the end of EXEC, alu_result_i and alu_zero_i SHALL be captured into result_o/zero_o and the state SHALL move to DONE.
REQ-019 Latency: accept at edge N -> ALU driven during cycle N+1 -> valid_o=1 after edge N+2.
REQ-020 In DONE valid_o=1 and result_o, zero_o, illegal_o SHALL stay stable until ready_i=1.
REQ-021 DONE & ready_i & valid_i SHALL hand off the current result and accept the new request in the same cycle (DONE->EXEC); DONE & ready_i & ~valid_i -> IDLE.
REQ-022 op_count_o SHALL increment by 1 on each hand-off (valid_o & ready_i), wrapping from 2^CNT_W-1 to 0.
REQ-023 Decode: aluop 000 -> 0010 (add); 001 -> 0110 (sub); 011 -> 0111 (slt); 100 -> 0001 (or); 010 -> by funct.
REQ-024 R-type funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100.
REQ-025 Any other aluop or funct SHALL decode to 1111 with illegal flag set; the op SHALL still complete with normal latency (ALU returns 0, zero_o=1).
REQ-026 illegal_o SHALL be valid only while valid_o=1 and 0 otherwise.
REQ-027 alu_ctrl_o SHALL be 1111 and operand outputs 0 outside EXEC.
REQ-028 valid_i while ready_o=0 SHALL be ignored (no capture, no state change).

Reset
REQ-029 rst_i=1 SHALL immediately force IDLE, valid_o=0, result_o=0, zero_o=0, illegal_o=0, op_count_o=0, alu_ctrl_o=1111, operands 0, ready_o=1 after release.
REQ-030 Reset during EXEC or DONE SHALL discard the in-flight operation without hand-off or count increment.

Verification
REQ-031 aluop=010, funct=100010, src1=7, src2=7, ready_i=1 -> alu_ctrl_o=0110 in cycle N+1; valid_o at N+2 with result_o=0, zero_o=1, op_count_o=1 after hand-off.
REQ-032 Back-to-back: add 3+4 then slt 5<9 with valid_i held and ready_i=1 -> results 7 then 1 on consecutive DONE cycles, two-cycle spacing, count=2.
REQ-033 Backpressure: ready_i=0 for 5 cycles in DONE -> valid_o held, result_o stable, ready_o=0, count unchanged; ready_i=1 -> single hand-off.
REQ-034 aluop=010, funct=000000 -> alu_ctrl_o=1111, illegal_o=1, result_o=0 with valid_o.
REQ-035 Assert rst_i mid-EXEC -> valid_o=0 and state IDLE without a clock edge; no hand-off recorded.
REQ-036 CNT_W=4, 17 hand-offs -> op_count_o=1 (wrap verified).
